// File: rtl/df_filter_config_ctrl_pkg.sv
// Shared types and helpers for the filter configuration controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package df_filter_config_ctrl_pkg;

  // Sequencer phases; encodings are fixed so debug taps read the same across revisions
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  // Config word layout: {hp, wg[1:0]}
  localparam int CFG_W = 3;

  // Scan order walks the config space upward and wraps 7 -> 0
  function automatic logic [CFG_W-1:0] next_scan_config(input logic [CFG_W-1:0] cfg);
    return cfg + 3'd1;
  endfunction

endpackage

// File: rtl/df_filter_config_ctrl_down_counter.sv
// Loadable down counter with zero flag; saturates at zero.
// Latency: load/decrement visible one cycle after the edge; zero is combinational from count.
// Backpressure: none; en simply pauses the count.
module df_filter_config_ctrl_down_counter #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over counting; hold at zero rather than wrap
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (en && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/df_filter_config_ctrl.sv
// Sequences 3-bit config writes into the filter with setup/hold/settle phases; optional auto-scan.
// Latency: accept at cycle t -> enconfig high t+2..t+1+HOLD_CYCLES -> settled at t+2+HOLD_CYCLES+SETTLE_CYCLES.
// Backpressure: cfg_ready low whenever a sequence is in flight; host holds cfg_valid/cfg_data until accepted.
module df_filter_config_ctrl
  import df_filter_config_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES   = 3,
  parameter int SETTLE_CYCLES = 8,
  parameter int DWELL_W       = 8
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CFG_W-1:0]   cfg_data,
  input  logic               scan_en,
  input  logic [DWELL_W-1:0] scan_dwell,
  output logic               enconfig,
  output logic [CFG_W-1:0]   configin,
  output logic [CFG_W-1:0]   cur_config,
  output logic               busy,
  output logic               settled
);

  localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state;
  state_t             state_nxt;
  logic               phase_load;
  logic [CNT_W-1:0]   phase_load_val;
  logic               phase_en;
  logic               phase_zero;
  logic               dwell_load;
  logic [DWELL_W-1:0] dwell_reload;
  logic               dwell_en;
  logic               dwell_zero;
  logic               scan_en_q;
  logic               idle;
  logic               scan_expire;
  logic               start;
  logic [CFG_W-1:0]   req_cfg;

  assign idle      = (state == ST_IDLE);
  assign cfg_ready = idle;
  assign busy      = !idle;

  // A host request always wins over a coincident scan expiry
  assign scan_expire = idle && scan_en && scan_en_q && dwell_zero;
  assign start       = idle && (cfg_valid || scan_expire);
  assign req_cfg     = cfg_valid ? cfg_data : next_scan_config(cur_config);

  // Dwell of 0 behaves as 1 so scan always makes progress
  assign dwell_reload = (scan_dwell == '0) ? '0 : scan_dwell - DWELL_W'(1);
  assign dwell_load   = (!idle && (state_nxt == ST_IDLE)) || (scan_en && !scan_en_q);
  assign dwell_en     = idle && scan_en;

  // State register; reset lands in SETTLE because the filter pipeline starts unflushed
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ST_SETTLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and phase counter control
  always_comb begin
    state_nxt      = state;
    phase_load     = 1'b0;
    phase_load_val = '0;
    phase_en       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        state_nxt      = ST_HOLD;
        phase_load     = 1'b1;
        phase_load_val = CNT_W'(HOLD_CYCLES - 1);
      end
      ST_HOLD: begin
        if (phase_zero) begin
          state_nxt      = ST_SETTLE;
          phase_load     = 1'b1;
          phase_load_val = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          phase_en = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (phase_zero) begin
          state_nxt = ST_IDLE;
        end else begin
          phase_en = 1'b1;
        end
      end
      default: state_nxt = ST_SETTLE;
    endcase
  end

  // Registered outputs; configin only moves on the IDLE->SETUP edge so it is stable around enconfig
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      configin   <= '0;
      cur_config <= '0;
      enconfig   <= 1'b0;
      settled    <= 1'b0;
      scan_en_q  <= 1'b0;
    end else begin
      if (start) begin
        configin   <= req_cfg;
        cur_config <= req_cfg;
      end
      enconfig  <= (state_nxt == ST_HOLD);
      settled   <= (state_nxt == ST_IDLE);
      scan_en_q <= scan_en;
    end
  end

  df_filter_config_ctrl_down_counter #(
    .W       (CNT_W),
    .RST_VAL (CNT_W'(SETTLE_CYCLES - 1))
  ) u_phase_cnt (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (phase_load),
    .load_val (phase_load_val),
    .en       (phase_en),
    .zero     (phase_zero)
  );

  df_filter_config_ctrl_down_counter #(
    .W       (DWELL_W),
    .RST_VAL ('0)
  ) u_dwell_cnt (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (dwell_load),
    .load_val (dwell_reload),
    .en       (dwell_en),
    .zero     (dwell_zero)
  );

endmodule

// File: tb/tb_df_filter_config_ctrl.sv
// Directed bench for the filter configuration controller.
// Latency: checks cycle-exact phase timing against hand-derived values.
// Backpressure: exercises held-off host requests and scan/host priority.
module tb_df_filter_config_ctrl;

  logic       CLK;
  logic       nRST;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_data;
  logic       scan_en;
  logic [7:0] scan_dwell;
  logic       enconfig;
  logic [2:0] configin;
  logic [2:0] cur_config;
  logic       busy;
  logic       settled;

  int tests = 0;
  int fails = 0;

  df_filter_config_ctrl dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .scan_en    (scan_en),
    .scan_dwell (scan_dwell),
    .enconfig   (enconfig),
    .configin   (configin),
    .cur_config (cur_config),
    .busy       (busy),
    .settled    (settled)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  // Bounded wait for the controller to be idle and settled
  task automatic wait_settled(input int max_cycles);
    int n;
    n = 0;
    while (!(settled === 1'b1 && busy === 1'b0) && n < max_cycles) begin
      @(posedge CLK); #1;
      n++;
    end
    tests++;
    if (!(settled === 1'b1 && busy === 1'b0)) begin
      fails++;
      $display("FAIL wait_settled: timeout after %0d cycles, settled=%b busy=%b, required 1/0", n, settled, busy);
    end
  endtask

  // Present one host request for a single fire cycle; returns in cycle t+1
  task automatic host_fire(input logic [2:0] d);
    cfg_valid = 1'b1;
    cfg_data  = d;
    @(posedge CLK); #1;
    cfg_valid = 1'b0;
    cfg_data  = 3'b000;
  endtask

  task automatic test_reset;
    nRST = 1'b0; cfg_valid = 1'b0; cfg_data = 3'b000; scan_en = 1'b0; scan_dwell = 8'd0;
    #12;
    tests++;
    if ({cfg_ready, enconfig, configin, cur_config, busy, settled} !== {1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: got rdy=%b en=%b cin=%b cur=%b busy=%b set=%b, required 0 0 000 000 1 0",
               cfg_ready, enconfig, configin, cur_config, busy, settled);
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge CLK); #1;
      tests++;
      if (busy !== 1'b1 || settled !== 1'b0) begin
        fails++;
        $display("FAIL reset_settle_c%0d: busy=%b settled=%b, required 1 0", i, busy, settled);
      end
    end
    @(posedge CLK); #1;
    tests++;
    if ({settled, cfg_ready, busy, configin, enconfig} !== {1'b1, 1'b1, 1'b0, 3'b000, 1'b0}) begin
      fails++;
      $display("FAIL reset_done: set=%b rdy=%b busy=%b cin=%b en=%b, required 1 1 0 000 0",
               settled, cfg_ready, busy, configin, enconfig);
    end
  endtask

  task automatic test_host_write;
    logic [11:0] en_seen;
    logic [11:0] st_seen;
    int          cfg_bad;
    cfg_bad = 0;
    tests++;
    if (cfg_ready !== 1'b1) begin
      fails++;
      $display("FAIL host_ready: cfg_ready=%b, required 1", cfg_ready);
    end
    host_fire(3'b101);
    tests++;
    if ({configin, cur_config, enconfig, settled, busy, cfg_ready} !== {3'b101, 3'b101, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL host_setup: cin=%b cur=%b en=%b set=%b busy=%b rdy=%b, required 101 101 0 0 1 0",
               configin, cur_config, enconfig, settled, busy, cfg_ready);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      en_seen[i] = enconfig;
      st_seen[i] = settled;
      if (configin !== 3'b101) cfg_bad++;
    end
    tests++;
    if (en_seen !== 12'h007) begin
      fails++;
      $display("FAIL host_enconfig_window: got %b, required %b", en_seen, 12'h007);
    end
    tests++;
    if (st_seen !== 12'h800) begin
      fails++;
      $display("FAIL host_settled_time: got %b, required %b", st_seen, 12'h800);
    end
    tests++;
    if (cfg_bad !== 0) begin
      fails++;
      $display("FAIL host_configin_stable: %0d cycles off 101, required 0", cfg_bad);
    end
  endtask

  task automatic test_same_config;
    int en_cnt;
    en_cnt = 0;
    host_fire(3'b101);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL same_cfg_busy: busy=%b, required 1", busy);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (enconfig === 1'b1) en_cnt++;
    end
    tests++;
    if (en_cnt !== 3 || settled !== 1'b1) begin
      fails++;
      $display("FAIL same_cfg_seq: enconfig cycles=%0d settled=%b, required 3 1", en_cnt, settled);
    end
  endtask

  task automatic test_back_to_back;
    int bad;
    bad = 0;
    cfg_valid = 1'b1;
    cfg_data  = 3'b001;
    @(posedge CLK); #1;
    cfg_data = 3'b010;
    for (int i = 0; i < 12; i++) begin
      if (cfg_ready !== 1'b0 || configin !== 3'b001) bad++;
      @(posedge CLK); #1;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL b2b_held_off: %0d busy cycles accepted or changed config, required 0", bad);
    end
    tests++;
    if (cfg_ready !== 1'b1 || configin !== 3'b001) begin
      fails++;
      $display("FAIL b2b_first_idle: rdy=%b cin=%b, required 1 001", cfg_ready, configin);
    end
    @(posedge CLK); #1;
    cfg_valid = 1'b0;
    cfg_data  = 3'b000;
    tests++;
    if (configin !== 3'b010 || cur_config !== 3'b010 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_fire: cin=%b cur=%b busy=%b, required 010 010 1", configin, cur_config, busy);
    end
    wait_settled(20);
  endtask

  task automatic test_scan;
    int n;
    int cnt;
    host_fire(3'b110);
    wait_settled(20);
    scan_dwell = 8'd4;
    scan_en    = 1'b1;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (busy !== 1'b1 && n < 20);
    tests++;
    if (n !== 5 || cur_config !== 3'b111) begin
      fails++;
      $display("FAIL scan_first_step: after %0d cycles cur=%b, required 5 cycles and 111", n, cur_config);
    end
    wait_settled(20);
    cnt = 0;
    while (settled === 1'b1 && cnt < 20) begin
      cnt++;
      @(posedge CLK); #1;
    end
    tests++;
    if (cnt !== 4) begin
      fails++;
      $display("FAIL scan_dwell_len: settled for %0d cycles, required 4", cnt);
    end
    tests++;
    if (cur_config !== 3'b000 || configin !== 3'b000) begin
      fails++;
      $display("FAIL scan_wrap: cur=%b cin=%b, required 000 000", cur_config, configin);
    end
    scan_en = 1'b0;
    wait_settled(20);
    repeat (10) begin
      @(posedge CLK); #1;
    end
    tests++;
    if (cur_config !== 3'b000 || settled !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL scan_stop: cur=%b set=%b busy=%b, required 000 1 0", cur_config, settled, busy);
    end
  endtask

  task automatic test_priority;
    scan_dwell = 8'd4;
    scan_en    = 1'b1;
    repeat (4) begin
      @(posedge CLK); #1;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL prio_early_scan: busy=%b before expiry, required 0", busy);
    end
    cfg_valid = 1'b1;
    cfg_data  = 3'b011;
    @(posedge CLK); #1;
    cfg_valid = 1'b0;
    cfg_data  = 3'b000;
    scan_en   = 1'b0;
    tests++;
    if (cur_config !== 3'b011 || busy !== 1'b1) begin
      fails++;
      $display("FAIL prio_host_wins: cur=%b busy=%b, required 011 1", cur_config, busy);
    end
    wait_settled(20);
    repeat (6) begin
      @(posedge CLK); #1;
    end
    tests++;
    if (cur_config !== 3'b011 || busy !== 1'b0) begin
      fails++;
      $display("FAIL prio_no_extra_step: cur=%b busy=%b, required 011 0", cur_config, busy);
    end
  endtask

  task automatic test_dwell_zero;
    int n;
    scan_dwell = 8'd0;
    scan_en    = 1'b1;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (busy !== 1'b1 && n < 20);
    scan_en = 1'b0;
    tests++;
    if (n !== 2 || cur_config !== 3'b100) begin
      fails++;
      $display("FAIL dwell_zero: step after %0d cycles cur=%b, required 2 cycles and 100", n, cur_config);
    end
    wait_settled(20);
  endtask

  task automatic test_reset_mid;
    int bad;
    bad = 0;
    host_fire(3'b111);
    @(posedge CLK); #1;
    tests++;
    if (enconfig !== 1'b1) begin
      fails++;
      $display("FAIL mid_in_hold: enconfig=%b, required 1", enconfig);
    end
    #2;
    nRST = 1'b0;
    #1;
    tests++;
    if ({enconfig, cur_config, configin, busy, settled, cfg_ready} !== {1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL mid_async_reset: en=%b cur=%b cin=%b busy=%b set=%b rdy=%b, required 0 000 000 1 0 0",
               enconfig, cur_config, configin, busy, settled, cfg_ready);
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge CLK); #1;
      if (busy !== 1'b1 || settled !== 1'b0 || enconfig !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL mid_resettle: %0d of 7 cycles not busy/unsettled, required 0", bad);
    end
    @(posedge CLK); #1;
    tests++;
    if (settled !== 1'b1 || cur_config !== 3'b000) begin
      fails++;
      $display("FAIL mid_resettle_done: set=%b cur=%b, required 1 000", settled, cur_config);
    end
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_same_config();
    test_back_to_back();
    test_scan();
    test_priority();
    test_dwell_zero();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
